// File: rtl/a5_keystream_gen.sv
// A5/1 keystream generator: loads a 64-bit key and a 22-bit frame number,
// mixes for 100 majority steps, then delivers NUM_BITS keystream bits
// as 32-bit words over a valid/ready handshake.
module a5_keystream_gen #(
    parameter int unsigned NUM_BITS = 228
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [21:0] frame,
    output logic        busy,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic [31:0] ks_data,
    output logic        ks_last,
    output logic        done
);

    localparam int unsigned BITS_W      = $clog2(NUM_BITS + 1);
    localparam int unsigned CNT_W       = 7;
    localparam int unsigned KEY_STEPS   = 64;
    localparam int unsigned FRAME_STEPS = 22;
    localparam int unsigned MIX_STEPS   = 100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_LOAD_FRAME,
        S_MIX,
        S_GEN,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [18:0]         r1_q, r1_d;
    logic [21:0]         r2_q, r2_d;
    logic [22:0]         r3_q, r3_d;
    logic [63:0]         key_q, key_d;
    logic [21:0]         frame_q, frame_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BITS_W-1:0]   bits_left_q, bits_left_d;
    logic [4:0]          wbit_q, wbit_d;
    logic [31:0]         word_q, word_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;

    logic                maj;
    logic                in_bit;
    logic                out_bit;
    logic [18:0]         r1_maj;
    logic [21:0]         r2_maj;
    logic [22:0]         r3_maj;
    logic [31:0]         gen_word;

    function automatic logic [18:0] step_r1(input logic [18:0] r, input logic b);
        return {r[17:0], r[18] ^ r[17] ^ r[16] ^ r[13] ^ b};
    endfunction

    function automatic logic [21:0] step_r2(input logic [21:0] r, input logic b);
        return {r[20:0], r[21] ^ r[20] ^ b};
    endfunction

    function automatic logic [22:0] step_r3(input logic [22:0] r, input logic b);
        return {r[21:0], r[22] ^ r[21] ^ r[20] ^ r[7] ^ b};
    endfunction

    // Majority-clocked register candidates and the resulting output bit
    assign maj      = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
    assign r1_maj   = (r1_q[8]  == maj) ? step_r1(r1_q, 1'b0) : r1_q;
    assign r2_maj   = (r2_q[10] == maj) ? step_r2(r2_q, 1'b0) : r2_q;
    assign r3_maj   = (r3_q[10] == maj) ? step_r3(r3_q, 1'b0) : r3_q;
    assign out_bit  = r1_maj[18] ^ r2_maj[21] ^ r3_maj[22];
    assign gen_word = {word_q[30:0], out_bit};
    assign in_bit   = (state_q == S_LOAD_KEY) ? key_q[cnt_q[5:0]] : frame_q[cnt_q[4:0]];

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        key_d       = key_q;
        frame_d     = frame_q;
        cnt_d       = cnt_q;
        bits_left_d = bits_left_q;
        wbit_d      = wbit_q;
        word_d      = word_q;
        last_d      = last_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // done_q high means the previous session just ended; ignore start then
                if (start && !done_q) begin
                    state_d     = S_LOAD_KEY;
                    key_d       = key;
                    frame_d     = frame;
                    r1_d        = '0;
                    r2_d        = '0;
                    r3_d        = '0;
                    cnt_d       = '0;
                    bits_left_d = BITS_W'(NUM_BITS);
                    wbit_d      = '0;
                    word_d      = '0;
                    last_d      = 1'b0;
                end
            end
            S_LOAD_KEY: begin
                r1_d  = step_r1(r1_q, in_bit);
                r2_d  = step_r2(r2_q, in_bit);
                r3_d  = step_r3(r3_q, in_bit);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(KEY_STEPS - 1)) begin
                    state_d = S_LOAD_FRAME;
                    cnt_d   = '0;
                end
            end
            S_LOAD_FRAME: begin
                r1_d  = step_r1(r1_q, in_bit);
                r2_d  = step_r2(r2_q, in_bit);
                r3_d  = step_r3(r3_q, in_bit);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FRAME_STEPS - 1)) begin
                    state_d = S_MIX;
                    cnt_d   = '0;
                end
            end
            S_MIX: begin
                r1_d  = r1_maj;
                r2_d  = r2_maj;
                r3_d  = r3_maj;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MIX_STEPS - 1)) begin
                    state_d = S_GEN;
                    cnt_d   = '0;
                    wbit_d  = '0;
                end
            end
            S_GEN: begin
                r1_d        = r1_maj;
                r2_d        = r2_maj;
                r3_d        = r3_maj;
                bits_left_d = bits_left_q - BITS_W'(1);
                wbit_d      = wbit_q + 5'd1;
                word_d      = gen_word;
                if (wbit_q == 5'd31 || bits_left_q == BITS_W'(1)) begin
                    state_d = S_HOLD;
                    // left-align a short final word, zero-filling the low bits
                    word_d  = gen_word << (5'd31 - wbit_q);
                    last_d  = (bits_left_q == BITS_W'(1));
                end
            end
            S_HOLD: begin
                if (ks_ready) begin
                    if (last_q) begin
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        cnt_d       = '0;
                        bits_left_d = '0;
                        wbit_d      = '0;
                        last_d      = 1'b0;
                    end else begin
                        state_d = S_GEN;
                        wbit_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_HOLD);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            key_q       <= '0;
            frame_q     <= '0;
            cnt_q       <= '0;
            bits_left_q <= '0;
            wbit_q      <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            key_q       <= key_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            bits_left_q <= bits_left_d;
            wbit_q      <= wbit_d;
            word_q      <= word_d;
            last_q      <= last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign busy     = busy_q;
    assign ks_valid = valid_q;
    assign ks_data  = word_q;
    assign ks_last  = last_q;
    assign done     = done_q;

endmodule

// File: tb/tb_a5_keystream_gen.sv
// Self-checking bench for a5_keystream_gen against a bit-level A5/1 model.
module tb_a5_keystream_gen;

    localparam int unsigned NUM_BITS = 228;
    localparam int NWORDS = (NUM_BITS + 31) / 32;
    localparam logic [63:0] KV_KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0] KV_FRAME = 22'h134;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [63:0] key;
    logic [21:0] frame;
    logic        busy;
    logic        ks_valid;
    logic        ks_ready;
    logic [31:0] ks_data;
    logic        ks_last;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_word [NWORDS];
    logic [31:0] obs_word [16];
    logic        obs_last [16];
    int          obs_n;
    int          first_valid;
    int          done_cnt;
    int          done_cyc;
    logic        busy_at_done;
    int          extra_busy;
    bit          timeout;
    bit          stall_changed;
    logic [31:0] z_data;
    logic        z_valid, z_busy, z_last, z_done;

    always #5 clk = ~clk;

    a5_keystream_gen #(.NUM_BITS(NUM_BITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .key      (key),
        .frame    (frame),
        .busy     (busy),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .ks_data  (ks_data),
        .ks_last  (ks_last),
        .done     (done)
    );

    // Reference A5/1: unpacked bit arrays, 86 load steps, 100 mix steps, then NUM_BITS output bits
    task automatic model_run(input logic [63:0] k, input logic [21:0] f);
        bit r1 [19];
        bit r2 [22];
        bit r3 [23];
        bit inb, m, s1, s2, s3, fb;
        int votes, b;
        for (int i = 0; i < 19; i++) r1[i] = 1'b0;
        for (int i = 0; i < 22; i++) r2[i] = 1'b0;
        for (int i = 0; i < 23; i++) r3[i] = 1'b0;
        for (int i = 0; i < NWORDS; i++) exp_word[i] = 32'h0;
        for (int i = 0; i < 186 + int'(NUM_BITS); i++) begin
            if (i < 86) begin
                inb = (i < 64) ? k[i] : f[i-64];
                s1 = 1'b1; s2 = 1'b1; s3 = 1'b1;
            end else begin
                inb = 1'b0;
                votes = int'(r1[8]) + int'(r2[10]) + int'(r3[10]);
                m = (votes >= 2);
                s1 = (r1[8] == m); s2 = (r2[10] == m); s3 = (r3[10] == m);
            end
            if (s1) begin
                fb = r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ inb;
                for (int j = 18; j > 0; j--) r1[j] = r1[j-1];
                r1[0] = fb;
            end
            if (s2) begin
                fb = r2[21] ^ r2[20] ^ inb;
                for (int j = 21; j > 0; j--) r2[j] = r2[j-1];
                r2[0] = fb;
            end
            if (s3) begin
                fb = r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ inb;
                for (int j = 22; j > 0; j--) r3[j] = r3[j-1];
                r3[0] = fb;
            end
            if (i >= 186) begin
                b = i - 186;
                exp_word[b/32][31-(b%32)] = r1[18] ^ r2[21] ^ r3[22];
            end
        end
    endtask

    // Drives one session and records what the DUT produced; cycle n counts from the start-sampling edge
    task automatic run_session(input logic [63:0] k, input logic [21:0] f,
                               input int stall_word, input int stall_len, input bit rand_ready,
                               input bit chg, input bit poke, input int abort_word);
        int n, stalled, tail;
        logic [31:0] hold_data;
        bit poked2, done_seen;
        obs_n = 0; first_valid = -1; done_cnt = 0; done_cyc = -1; busy_at_done = 1'b1;
        extra_busy = 0; timeout = 0; stall_changed = 0; stalled = 0; tail = 0;
        poked2 = 0; done_seen = 0; hold_data = 32'h0;
        @(negedge clk);
        key = k; frame = f; start = 1'b1; ks_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; n = 1;
        if (chg) begin key = ~k; frame = ~f; end
        while (1) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = n; busy_at_done = busy; end
                done_seen = 1;
            end else if (done_seen && busy) extra_busy++;
            if (ks_valid && first_valid < 0) first_valid = n;
            if (ks_valid && obs_n == abort_word) begin
                reset_n = 1'b0;
                #1;
                z_data = ks_data; z_valid = ks_valid; z_busy = busy; z_last = ks_last; z_done = done;
                @(negedge clk);
                reset_n = 1'b1;
                start = 1'b0;
                return;
            end
            start = poke && (n == 120 || done || (ks_valid && obs_n == 1 && !poked2));
            if (poke && ks_valid && obs_n == 1) poked2 = 1;
            if (ks_valid && obs_n == stall_word && stalled > 0 && ks_data !== hold_data) stall_changed = 1;
            if (ks_valid && obs_n == stall_word && stalled < stall_len) begin
                if (stalled == 0) hold_data = ks_data;
                ks_ready = 1'b0;
                stalled++;
            end else begin
                ks_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (ks_valid && ks_ready && obs_n < 16) begin
                obs_word[obs_n] = ks_data;
                obs_last[obs_n] = ks_last;
                obs_n++;
            end
            if (done_seen) begin
                tail++;
                if (tail > 40) break;
            end
            if (n > 3000) begin timeout = 1; break; end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        ks_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; key = '0; frame = '0; ks_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (ks_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ks_valid); end
        n_checks++; if (ks_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", ks_last); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_after got=%b exp=0", busy); end
        n_checks++; if (ks_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=00000000", ks_data); end
    endtask

    task automatic test_known_vector();
        model_run(KV_KEY, KV_FRAME);
        run_session(KV_KEY, KV_FRAME, -1, 0, 0, 0, 0, -1);
        n_checks++; if (timeout) begin n_fail++; $display("FAIL kv_timeout got=1 exp=0"); end
        n_checks++; if (obs_n !== NWORDS) begin n_fail++; $display("FAIL kv_nwords got=%0d exp=%0d", obs_n, NWORDS); end
        n_checks++; if (first_valid !== 219) begin n_fail++; $display("FAIL kv_first_valid got=%0d exp=219", first_valid); end
        n_checks++; if (obs_word[0] !== 32'h534EAA58) begin n_fail++; $display("FAIL kv_word0 got=%h exp=534eaa58", obs_word[0]); end
        n_checks++; if (obs_word[1] !== 32'h2FE8151A) begin n_fail++; $display("FAIL kv_word1 got=%h exp=2fe8151a", obs_word[1]); end
        for (int w = 0; w < NWORDS; w++) begin
            n_checks++;
            if (obs_word[w] !== exp_word[w] || obs_last[w] !== (w == NWORDS - 1)) begin
                n_fail++;
                $display("FAIL kv_word%0d got=%h/%b exp=%h/%b", w, obs_word[w], obs_last[w], exp_word[w], (w == NWORDS - 1));
            end
        end
        n_checks++; if (obs_word[7][27:0] !== 28'h0) begin n_fail++; $display("FAIL kv_word7_pad got=%h exp=0", obs_word[7][27:0]); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL kv_done_count got=%0d exp=1", done_cnt); end
        n_checks++; if (done_cyc !== 423) begin n_fail++; $display("FAIL kv_done_cycle got=%0d exp=423", done_cyc); end
        n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL kv_busy_at_done got=%b exp=0", busy_at_done); end
    endtask

    task automatic test_backpressure();
        model_run(KV_KEY, KV_FRAME);
        run_session(KV_KEY, KV_FRAME, 2, 50, 0, 0, 0, -1);
        n_checks++; if (timeout) begin n_fail++; $display("FAIL bp_timeout got=1 exp=0"); end
        n_checks++; if (stall_changed) begin n_fail++; $display("FAIL bp_data_stable got=changed exp=stable"); end
        for (int w = 0; w < NWORDS; w++) begin
            n_checks++;
            if (obs_word[w] !== exp_word[w]) begin n_fail++; $display("FAIL bp_word%0d got=%h exp=%h", w, obs_word[w], exp_word[w]); end
        end
        n_checks++; if (done_cyc !== 473) begin n_fail++; $display("FAIL bp_done_cycle got=%0d exp=473", done_cyc); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        model_run(KV_KEY, KV_FRAME);
        run_session(KV_KEY, KV_FRAME, -1, 0, 0, 0, 1, -1);
        n_checks++; if (obs_n !== NWORDS) begin n_fail++; $display("FAIL si_nwords got=%0d exp=%0d", obs_n, NWORDS); end
        for (int w = 0; w < NWORDS; w++) begin
            n_checks++;
            if (obs_word[w] !== exp_word[w]) begin n_fail++; $display("FAIL si_word%0d got=%h exp=%h", w, obs_word[w], exp_word[w]); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL si_done_count got=%0d exp=1", done_cnt); end
        n_checks++; if (extra_busy !== 0) begin n_fail++; $display("FAIL si_second_session got=%0d exp=0", extra_busy); end
        n_checks++; if (done_cyc !== 423) begin n_fail++; $display("FAIL si_done_cycle got=%0d exp=423", done_cyc); end
    endtask

    task automatic test_input_change();
        model_run(KV_KEY, KV_FRAME);
        run_session(KV_KEY, KV_FRAME, -1, 0, 0, 1, 0, -1);
        n_checks++; if (obs_word[0] !== 32'h534EAA58) begin n_fail++; $display("FAIL ic_word0 got=%h exp=534eaa58", obs_word[0]); end
        for (int w = 1; w < NWORDS; w++) begin
            n_checks++;
            if (obs_word[w] !== exp_word[w]) begin n_fail++; $display("FAIL ic_word%0d got=%h exp=%h", w, obs_word[w], exp_word[w]); end
        end
    endtask

    task automatic test_abort();
        run_session(KV_KEY, KV_FRAME, -1, 0, 0, 0, 0, 3);
        n_checks++; if (z_valid !== 1'b0) begin n_fail++; $display("FAIL ab_valid got=%b exp=0", z_valid); end
        n_checks++; if (z_busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy got=%b exp=0", z_busy); end
        n_checks++; if (z_data !== 32'h0) begin n_fail++; $display("FAIL ab_data got=%h exp=00000000", z_data); end
        n_checks++; if (z_last !== 1'b0 || z_done !== 1'b0) begin n_fail++; $display("FAIL ab_last_done got=%b%b exp=00", z_last, z_done); end
        n_checks++; if (obs_n !== 3) begin n_fail++; $display("FAIL ab_words_before got=%0d exp=3", obs_n); end
        repeat (5) @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ab_idle_after got=%b%b exp=00", done, busy); end
        model_run(KV_KEY, KV_FRAME);
        run_session(KV_KEY, KV_FRAME, -1, 0, 0, 0, 0, -1);
        n_checks++; if (obs_word[0] !== 32'h534EAA58) begin n_fail++; $display("FAIL ab_restart_word0 got=%h exp=534eaa58", obs_word[0]); end
        n_checks++; if (first_valid !== 219) begin n_fail++; $display("FAIL ab_restart_first_valid got=%0d exp=219", first_valid); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ab_restart_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_random();
        logic [63:0] k;
        logic [21:0] f;
        for (int it = 0; it < 4; it++) begin
            k = {$urandom, $urandom};
            f = 22'($urandom);
            model_run(k, f);
            run_session(k, f, -1, 0, 1, 0, 0, -1);
            n_checks++; if (timeout || obs_n !== NWORDS) begin n_fail++; $display("FAIL rnd%0d_nwords got=%0d exp=%0d", it, obs_n, NWORDS); end
            for (int w = 0; w < NWORDS; w++) begin
                n_checks++;
                if (obs_word[w] !== exp_word[w] || obs_last[w] !== (w == NWORDS - 1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_word%0d got=%h/%b exp=%h/%b", it, w, obs_word[w], obs_last[w], exp_word[w], (w == NWORDS - 1));
                end
            end
            n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rnd%0d_done got=%0d exp=1", it, done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_backpressure();
        test_start_ignored();
        test_input_change();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/a5_keystream_gen.md
A5_KEYSTREAM_GEN -- requirements
Module: a5_keystream_gen

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 228, giving the keystream bits per session; the legal range SHALL be 1..1023.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, shared with the wishbone bus clock (wb_clk_i).
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset, the same reset used by the wishbone interface.
REQ-004 The block SHALL have port start, input, 1 bit: session request, sampled only in IDLE.
REQ-005 The block SHALL have port key, input, 64 bits: session key; key[i] is loaded at key step i.
REQ-006 The block SHALL have port frame, input, 22 bits: frame number; frame[i] is loaded at frame step i.
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have port ks_valid, output, 1 bit: ks_data holds a complete keystream word.
REQ-009 The block SHALL have port ks_ready, input, 1 bit: the consumer (wishbone interface) accepts the word.
REQ-010 The block SHALL have port ks_data, output, 32 bits: keystream word, with the first-generated bit at ks_data[31].
REQ-011 The block SHALL have port ks_last, output, 1 bit: qualifies the final word of the session.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final word transfers.

Function
REQ-013 The block SHALL contain three LFSRs with these taps (XOR of tap bits gives the feedback) and clocking bits:
- R1: 19 bits, taps 18,17,16,13, clocking bit 8.
- R2: 22 bits, taps 21,20, clocking bit 10.
- R3: 23 bits, taps 22,21,20,7, clocking bit 10.
REQ-014 A register step SHALL shift left by one and insert the feedback bit at bit 0.
REQ-015 A key step or frame step SHALL step all three registers, with bit 0 set to feedback XOR the input bit.
REQ-016 A majority step SHALL step only those registers whose clocking bit equals the majority of the three clocking bits.
REQ-017 The output bit SHALL be R1[18]^R2[21]^R3[22], taken from the register state after that cycle's step.
REQ-018 The block SHALL implement the state machine IDLE -> LOAD_KEY -> LOAD_FRAME -> MIX -> GEN <-> HOLD -> IDLE, with these states:
- IDLE: idle.
- LOAD_KEY: 64 key steps.
- LOAD_FRAME: 22 frame steps.
- MIX: 100 majority steps, output discarded.
- GEN: 1 majority step per cycle, output bit shifted into the word register.
- HOLD: word presented to the consumer.
REQ-019 When start is high in IDLE, key and frame SHALL be captured into internal registers, R1/R2/R3 SHALL be zeroed, and the block SHALL enter LOAD_KEY; key and frame may change afterwards.
REQ-020 GEN SHALL exit to HOLD after 32 bits, or after the remaining bits if fewer than 32 remain.
REQ-021 A partial final word SHALL be left-aligned, with unused low bits zero.
REQ-022 In HOLD, ks_valid SHALL be 1; ks_data and ks_last SHALL be stable; and R1/R2/R3 SHALL not step.
REQ-023 A transfer SHALL occur at a rising edge where ks_valid&&ks_ready; the next state SHALL then be GEN, or IDLE if ks_last.
REQ-024 ks_valid SHALL deassert on the cycle after the transfer.
REQ-025 ks_valid SHALL never be high outside HOLD.
REQ-026 ks_ready SHALL be ignored outside HOLD.
REQ-027 ks_ready held low SHALL stall HOLD indefinitely with no loss or change of data.
REQ-028 done SHALL pulse high for exactly one cycle, on the cycle after the final transfer, coincident with busy=0.
REQ-029 start SHALL be ignored while busy=1, including in the cycle done is high.
REQ-030 Timing SHALL be as follows, taking the edge that samples start as edge 0:
- LOAD_KEY occupies cycles 1-64.
- LOAD_FRAME occupies cycles 65-86.
- MIX occupies cycles 87-186.
- The first GEN cycle is cycle 187.
- ks_valid first rises at cycle 219.
REQ-031 With ks_ready tied high, each full word SHALL cost 33 cycles (32 GEN + 1 HOLD).
REQ-032 With NUM_BITS=228 the session SHALL produce 8 words (7 full words plus 1 word with 4 valid bits), with ks_last=1 on word 8 only.
REQ-033 Bit and word counters SHALL be sized for NUM_BITS and SHALL clear on entry to IDLE.

Reset
REQ-034 On reset_n low the block SHALL asynchronously enter IDLE, with R1/R2/R3, the word register, the captured key and frame, and all counters cleared to 0.
REQ-035 After reset, ks_valid, ks_last, done and busy SHALL be 0, and ks_data SHALL be 32'h0.
REQ-036 Reset asserted mid-session (any state, including HOLD with ks_valid=1) SHALL abort the session; no done pulse SHALL be produced.
REQ-037 The first start after reset_n deasserts SHALL begin a fresh session.

Verification
REQ-038 Known vector: key=64'hEFCDAB8967452312, frame=22'h134, ks_ready=1 -> word0=32'h534EAA58 and word1=32'h2FE8151A.
REQ-039 Known vector, full session: ks_valid first rises at cycle 219; the session ends with 8 words; word7 has ks_last=1, bits [27:0]=0, and done pulses once.
REQ-040 Backpressure: ks_ready=0 for 50 cycles during word2 -> ks_data is constant; the session output is bit-identical to REQ-038/REQ-039; completion is 50 cycles later.
REQ-041 start pulsed during MIX and again during HOLD -> no effect on the output, and no second session.
REQ-042 reset_n asserted in HOLD of word3, then start reissued with the same key and frame -> outputs zero immediately, and the new session reproduces word0=32'h534EAA58.
REQ-043 key and frame changed on the cycle after start -> output unchanged from REQ-038.
